// File: rtl/sdram_aref_if.sv
// Refresh-generator side of the command arbiter: request/grant handshake plus the
// command and address this block drives onto the SDRAM bus while it owns it.
interface sdram_aref_if;
    logic        aref_en;
    logic        aref_req;
    logic        aref_busy;
    logic        aref_end;
    logic        aref_miss;
    logic [3:0]  aref_cmd;
    logic [11:0] aref_addr;

    modport master (
        input  aref_en,
        output aref_req, aref_busy, aref_end, aref_miss, aref_cmd, aref_addr
    );

    modport slave (
        output aref_en,
        input  aref_req, aref_busy, aref_end, aref_miss, aref_cmd, aref_addr
    );
endinterface

// File: rtl/sdram_aref.sv
// SDRAM auto-refresh generator: times the refresh interval, requests the bus and,
// once granted, issues PRECHARGE-ALL followed by AREF_NUM AUTO REFRESH commands.
module sdram_aref #(
    parameter int REF_CYCLES  = 780,
    parameter int TRP_CYCLES  = 2,   // must be >= 1
    parameter int TRFC_CYCLES = 7,   // must be >= 1
    parameter int AREF_NUM    = 1    // 1..4
) (
    input  logic          sclk,
    input  logic          srst,
    input  logic          flag_init_end,
    sdram_aref_if.master  bus
);
    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_PRE  = 4'b0010;
    localparam logic [3:0]  CMD_AREF = 4'b0001;
    localparam logic [11:0] ADDR_ALL = 12'h400;

    typedef enum logic [2:0] {IDLE, PRE, WAIT_TRP, AREF, WAIT_TRFC} state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_nxt;
    logic [2:0]  num, num_nxt;
    logic [9:0]  ref_cnt;
    logic        grant, wrap;

    logic        req_q, busy_q, end_q, miss_q;
    logic [3:0]  cmd_q, cmd_nxt;
    logic [11:0] addr_q;
    logic        end_nxt;

    assign grant = (state == IDLE) && req_q && bus.aref_en;
    assign wrap  = flag_init_end && (ref_cnt == 10'(REF_CYCLES - 1));

    // Interval timer is free-running once init is done; a pending request never stalls it.
    always_ff @(posedge sclk) begin
        if (srst || !flag_init_end) ref_cnt <= '0;
        else if (wrap)              ref_cnt <= '0;
        else                        ref_cnt <= ref_cnt + 10'd1;
    end

    // A wrap coinciding with a grant re-arms the request without counting a miss.
    always_ff @(posedge sclk) begin
        if (srst || !flag_init_end) begin
            req_q  <= 1'b0;
            miss_q <= srst ? 1'b0 : miss_q;
        end else if (wrap) begin
            req_q <= 1'b1;
            if (req_q && !grant) miss_q <= 1'b1;
        end else if (grant) begin
            req_q <= 1'b0;
        end
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            num      <= '0;
            cmd_q    <= CMD_NOP;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            num      <= num_nxt;
            cmd_q    <= cmd_nxt;
            addr_q   <= (state_nxt == PRE) ? ADDR_ALL : 12'h000;
            busy_q   <= (state_nxt != IDLE);
            end_q    <= end_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        num_nxt   = num;
        case (state)
            IDLE: begin
                num_nxt = '0;
                if (grant) state_nxt = PRE;
            end
            PRE: begin
                state_nxt = WAIT_TRP;
                wait_nxt  = 4'(TRP_CYCLES - 1);
            end
            WAIT_TRP: begin
                if (wait_cnt == 4'd0) state_nxt = AREF;
                else                  wait_nxt  = wait_cnt - 4'd1;
            end
            AREF: begin
                state_nxt = WAIT_TRFC;
                wait_nxt  = 4'(TRFC_CYCLES - 1);
                num_nxt   = num + 3'd1;
            end
            WAIT_TRFC: begin
                if (wait_cnt != 4'd0)            wait_nxt  = wait_cnt - 4'd1;
                else if (num == 3'(AREF_NUM))    state_nxt = IDLE;
                else                             state_nxt = AREF;
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state itself.
        cmd_nxt = CMD_NOP;
        if (state_nxt == PRE)  cmd_nxt = CMD_PRE;
        if (state_nxt == AREF) cmd_nxt = CMD_AREF;
        end_nxt = (state_nxt == WAIT_TRFC) && (wait_nxt == 4'd0) && (num_nxt == 3'(AREF_NUM));
    end

    assign bus.aref_req  = req_q;
    assign bus.aref_busy = busy_q;
    assign bus.aref_end  = end_q;
    assign bus.aref_miss = miss_q;
    assign bus.aref_cmd  = cmd_q;
    assign bus.aref_addr = addr_q;
endmodule

// File: tb/tb_sdram_aref.sv
// Directed bench for sdram_aref: one instance with AREF_NUM=1 and one with AREF_NUM=2,
// driven in lockstep; per-cycle bus expectations come from a scoreboard queue.
module tb_sdram_aref;
    logic sclk = 1'b0;
    logic srst;
    logic flag_init_end;

    always #5 sclk = ~sclk;

    sdram_aref_if aif1();
    sdram_aref_if aif2();

    sdram_aref #(.AREF_NUM(1)) dut1 (.sclk(sclk), .srst(srst), .flag_init_end(flag_init_end), .bus(aif1.master));
    sdram_aref #(.AREF_NUM(2)) dut2 (.sclk(sclk), .srst(srst), .flag_init_end(flag_init_end), .bus(aif2.master));

    typedef struct packed {
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic        busy;
        logic        fin;
    } exp_t;

    localparam exp_t IDLE_E = '{cmd: 4'b0111, addr: 12'h000, busy: 1'b0, fin: 1'b0};

    exp_t q1[$];
    exp_t q2[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Expected bus activity for one granted sequence, cycle by cycle after the grant edge.
    task automatic push_seq(input int which, input int num);
        exp_t s[$];
        s.push_back('{cmd: 4'b0010, addr: 12'h400, busy: 1'b1, fin: 1'b0});
        for (int i = 0; i < 2; i++) s.push_back('{cmd: 4'b0111, addr: 12'h000, busy: 1'b1, fin: 1'b0});
        for (int r = 0; r < num; r++) begin
            s.push_back('{cmd: 4'b0001, addr: 12'h000, busy: 1'b1, fin: 1'b0});
            for (int i = 0; i < 7; i++)
                s.push_back('{cmd: 4'b0111, addr: 12'h000, busy: 1'b1,
                              fin: (r == num - 1 && i == 6)});
        end
        foreach (s[k]) begin
            if (which == 1) q1.push_back(s[k]);
            else            q2.push_back(s[k]);
        end
    endtask

    task automatic cyc();
        exp_t e1, e2;
        @(posedge sclk);
        @(negedge sclk);
        e1 = (q1.size() > 0) ? q1.pop_front() : IDLE_E;
        e2 = (q2.size() > 0) ? q2.pop_front() : IDLE_E;
        chk("d1_cmd",  16'(aif1.aref_cmd),  16'(e1.cmd));
        chk("d1_addr", 16'(aif1.aref_addr), 16'(e1.addr));
        chk("d1_busy", 16'(aif1.aref_busy), 16'(e1.busy));
        chk("d1_end",  16'(aif1.aref_end),  16'(e1.fin));
        chk("d2_cmd",  16'(aif2.aref_cmd),  16'(e2.cmd));
        chk("d2_addr", 16'(aif2.aref_addr), 16'(e2.addr));
        chk("d2_busy", 16'(aif2.aref_busy), 16'(e2.busy));
        chk("d2_end",  16'(aif2.aref_end),  16'(e2.fin));
    endtask

    task automatic chk_req(input string tag, input logic req, input logic miss);
        chk({tag, "_req1"},  16'(aif1.aref_req),  16'(req));
        chk({tag, "_req2"},  16'(aif2.aref_req),  16'(req));
        chk({tag, "_miss1"}, 16'(aif1.aref_miss), 16'(miss));
        chk({tag, "_miss2"}, 16'(aif2.aref_miss), 16'(miss));
    endtask

    task automatic set_en(input logic v);
        aif1.aref_en = v;
        aif2.aref_en = v;
    endtask

    initial begin
        srst = 1'b1;
        flag_init_end = 1'b0;
        set_en(1'b0);

        // T1: reset, then a long hold with init not finished
        repeat (3) begin cyc(); chk_req("rst", 1'b0, 1'b0); end
        srst = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            set_en(i == 500);
            cyc();
            chk_req("noinit", 1'b0, 1'b0);
        end
        set_en(1'b0);

        // T2: request after 780 cycles, miss after 1560
        flag_init_end = 1'b1;
        for (int i = 0; i < 779; i++) begin cyc(); chk_req("t2_pre", 1'b0, 1'b0); end
        cyc(); chk_req("t2_req", 1'b1, 1'b0);
        for (int i = 0; i < 779; i++) begin cyc(); chk_req("t2_hold", 1'b1, 1'b0); end
        cyc(); chk_req("t2_miss", 1'b1, 1'b1);

        // T3/T4: grant, single vs double refresh sequences
        push_seq(1, 1);
        push_seq(2, 2);
        set_en(1'b1);
        cyc();
        set_en(1'b0);
        chk_req("t3_grant", 1'b0, 1'b1);
        for (int i = 0; i < 22; i++) begin
            set_en(i == 4);
            cyc();
        end
        set_en(1'b0);
        chk_req("t3_after", 1'b0, 1'b1);

        // T5: reset clears state, then abandon a sequence mid-flight
        srst = 1'b1;
        cyc(); chk_req("t5_rst", 1'b0, 1'b0);
        srst = 1'b0;
        for (int i = 0; i < 779; i++) begin cyc(); chk_req("t5_pre", 1'b0, 1'b0); end
        cyc(); chk_req("t5_req", 1'b1, 1'b0);
        push_seq(1, 1);
        push_seq(2, 2);
        set_en(1'b1);
        cyc();
        set_en(1'b0);
        repeat (3) cyc();
        srst = 1'b1;
        q1.delete();
        q2.delete();
        cyc(); chk_req("t5_abort", 1'b0, 1'b0);
        srst = 1'b0;
        for (int i = 0; i < 779; i++) begin cyc(); chk_req("t5_gap", 1'b0, 1'b0); end
        cyc(); chk_req("t5_next", 1'b1, 1'b0);

        // T6: grant on the wrap edge keeps the new request alive, no miss
        for (int i = 0; i < 779; i++) begin cyc(); chk_req("t6_hold", 1'b1, 1'b0); end
        push_seq(1, 1);
        push_seq(2, 2);
        set_en(1'b1);
        cyc();
        set_en(1'b0);
        chk_req("t6_wrapgrant", 1'b1, 1'b0);
        for (int i = 0; i < 22; i++) begin
            set_en(i == 2);
            cyc();
        end
        set_en(1'b0);
        chk_req("t6_after", 1'b1, 1'b0);

        // The re-armed request is then served normally
        push_seq(1, 1);
        push_seq(2, 2);
        set_en(1'b1);
        cyc();
        set_en(1'b0);
        chk_req("t6_regrant", 1'b0, 1'b0);
        repeat (21) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
